// File: rtl/acc_sched_pkg.sv
// Shared types and helpers for the accumulator write scheduler and its arbiter.
package acc_sched_pkg;

  // Tile sequencing phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    XFER  = 2'd3
  } sched_state_e;

  // Element width codes carried to the buffer for the whole tile.
  localparam logic [1:0] BW_SMALL = 2'd0;
  localparam logic [1:0] BW_MED   = 2'd1;
  localparam logic [1:0] BW_LARGE = 2'd2;

  // Row/column index width for a square tile of tile_size entries per side.
  function automatic int row_width(input int tile_size);
    return (tile_size > 1) ? $clog2(tile_size) : 1;
  endfunction

  // Partial-sum width: four times the smallest element width.
  function automatic int data_width(input int smallest_element_width);
    return 4 * smallest_element_width;
  endfunction

  // Pointer width for an n-way arbiter; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accumulator_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a rotating pointer.
// The pointer moves to one past the winner only when the caller reports that
// the grant was taken, so an unused grant does not cost a requester its turn.
module rr_arbiter
  import acc_sched_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search ascending from rr_ptr with wrap; the first asserted request wins.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
        idx = sum[PTR_W-1:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  // Rotate the pointer past the winner once its grant is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/accumulator_write_scheduler.sv
// Accumulator write scheduler: shares the buffer's single accumulate-write
// port among NUM_REQ producer lanes and walks each tile through
// IDLE -> ACCUM -> FLUSH -> XFER.
// Optional statistics counters are compiled in with ACC_SCHED_STATS_EN.
module accumulator_write_scheduler
  import acc_sched_pkg::*;
#(
  parameter int  NUM_REQ                = 4,
  parameter int  TILE_SIZE              = 256,
  parameter int  SMALLEST_ELEMENT_WIDTH = 4,
  localparam int ROW_W                  = row_width(TILE_SIZE),
  localparam int DATA_W                 = data_width(SMALLEST_ELEMENT_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                bitwidth_in,
  input  logic                      drain,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ROW_W-1:0]  req_row,
  input  logic [NUM_REQ*ROW_W-1:0]  req_col,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [ROW_W-1:0]          buffer_row_write,
  output logic [ROW_W-1:0]          buffer_column_write,
  output logic [DATA_W-1:0]         buffer_data_write,
  output logic                      buffer_write_enable,
  output logic                      transfer,
  output logic [1:0]                bitwidth,
  output logic                      busy,
  output logic                      done
`ifdef ACC_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_writes,
  output logic [31:0]               stat_stall
`endif
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  sched_state_e        state;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                accept;
  logic [ROW_W-1:0]    sel_row;
  logic [ROW_W-1:0]    sel_col;
  logic [DATA_W-1:0]   sel_data;

  // Grants are only offered while accumulating; other states see no ready.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .enable    (state == ACCUM),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);

  // One-hot AND-OR select of the granted lane's row, column and data.
  always_comb begin
    sel_row  = '0;
    sel_col  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_row  = sel_row  | req_row [i*ROW_W  +: ROW_W];
        sel_col  = sel_col  | req_col [i*ROW_W  +: ROW_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tile sequencer with registered write bus, strobes and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      bitwidth            <= BW_SMALL;
      busy                <= 1'b0;
      transfer            <= 1'b0;
      done                <= 1'b0;
      buffer_write_enable <= 1'b0;
      buffer_row_write    <= '0;
      buffer_column_write <= '0;
      buffer_data_write   <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the case below, so single-cycle strobes fall back to 0 automatically.
      buffer_write_enable <= 1'b0;
      transfer            <= 1'b0;
      done                <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            bitwidth <= bitwidth_in;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          // A grant taken alongside drain is still written on this edge.
          if (accept) begin
            buffer_row_write    <= sel_row;
            buffer_column_write <= sel_col;
            buffer_data_write   <= sel_data;
            buffer_write_enable <= 1'b1;
          end
          if (drain) state <= FLUSH;
        end
        FLUSH: begin
          // The final write is on the bus this cycle; pulse transfer next.
          state    <= XFER;
          transfer <= 1'b1;
          done     <= 1'b1;
        end
        XFER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_SCHED_STATS_EN
  logic multi_valid;

  // More than one requester valid means at least one of them waits this cycle.
  assign multi_valid = |(req_valid & (req_valid - 1'b1));

  // Saturating write and stall counters, cleared when a tile starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_writes <= '0;
      stat_stall  <= '0;
    end else if (state == IDLE && start) begin
      stat_writes <= '0;
      stat_stall  <= '0;
    end else if (state == ACCUM) begin
      if (accept && stat_writes != '1) stat_writes <= stat_writes + 32'd1;
      if (multi_valid && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_accumulator_write_scheduler.sv
// Self-checking bench for accumulator_write_scheduler. A behavioural model of
// the tile phases and round-robin fairness predicts every output each cycle.
// Define ACC_SCHED_STATS_EN to also exercise the statistics counters.
module tb_accumulator_write_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TILE_SIZE = 256;
  localparam int SEW = 4;
  localparam int ROW_W = 8;
  localparam int DATA_W = 16;

  localparam int S_IDLE = 0;
  localparam int S_ACC = 1;
  localparam int S_FLUSH = 2;
  localparam int S_XFER = 3;

  logic clk;
  logic reset_n;
  logic start;
  logic [1:0] bitwidth_in;
  logic drain;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ROW_W-1:0] req_row;
  logic [NUM_REQ*ROW_W-1:0] req_col;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ROW_W-1:0] buffer_row_write;
  logic [ROW_W-1:0] buffer_column_write;
  logic [DATA_W-1:0] buffer_data_write;
  logic buffer_write_enable;
  logic transfer;
  logic [1:0] bitwidth;
  logic busy;
  logic done;
`ifdef ACC_SCHED_STATS_EN
  logic [31:0] stat_writes;
  logic [31:0] stat_stall;
`endif

  accumulator_write_scheduler #(
    .NUM_REQ(NUM_REQ),
    .TILE_SIZE(TILE_SIZE),
    .SMALLEST_ELEMENT_WIDTH(SEW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bitwidth_in(bitwidth_in),
    .drain(drain),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_row(req_row),
    .req_col(req_col),
    .req_data(req_data),
    .buffer_row_write(buffer_row_write),
    .buffer_column_write(buffer_column_write),
    .buffer_data_write(buffer_data_write),
    .buffer_write_enable(buffer_write_enable),
    .transfer(transfer),
    .bitwidth(bitwidth),
    .busy(busy),
    .done(done)
`ifdef ACC_SCHED_STATS_EN
    ,
    .stat_writes(stat_writes),
    .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model state.
  int m_state;
  int m_last;
  logic m_en;
  logic [ROW_W-1:0] m_row;
  logic [ROW_W-1:0] m_col;
  logic [DATA_W-1:0] m_data;
  logic [1:0] m_bw;
  longint m_writes;
  longint m_stall;
  int grant_log[$];

  task automatic model_reset();
    m_state = S_IDLE;
    m_last = NUM_REQ - 1;
    m_en = 1'b0;
    m_row = '0;
    m_col = '0;
    m_data = '0;
    m_bw = 2'd0;
    m_writes = 0;
    m_stall = 0;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_row[i*ROW_W +: ROW_W] = ROW_W'($urandom);
      req_col[i*ROW_W +: ROW_W] = ROW_W'($urandom);
      req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  // One clock cycle: inputs already driven; compare at negedge, advance model.
  task automatic cycle(input string tag);
    logic [NUM_REQ-1:0] exp_grant;
    int gi;
    exp_grant = '0;
    gi = -1;
    if (m_state == S_ACC) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (gi < 0 && req_valid[(m_last + k) % NUM_REQ]) gi = (m_last + k) % NUM_REQ;
      end
    end
    if (gi >= 0) exp_grant[gi] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== exp_grant) begin bad++; $display("FAIL %s req_ready got=%b want=%b", tag, req_ready, exp_grant); end
    total++;
    if (buffer_write_enable !== m_en) begin bad++; $display("FAIL %s write_enable got=%b want=%b", tag, buffer_write_enable, m_en); end
    total++;
    if (buffer_row_write !== m_row) begin bad++; $display("FAIL %s row got=%0d want=%0d", tag, buffer_row_write, m_row); end
    total++;
    if (buffer_column_write !== m_col) begin bad++; $display("FAIL %s col got=%0d want=%0d", tag, buffer_column_write, m_col); end
    total++;
    if (buffer_data_write !== m_data) begin bad++; $display("FAIL %s data got=%h want=%h", tag, buffer_data_write, m_data); end
    total++;
    if (transfer !== (m_state == S_XFER)) begin bad++; $display("FAIL %s transfer got=%b want=%b", tag, transfer, m_state == S_XFER); end
    total++;
    if (done !== (m_state == S_XFER)) begin bad++; $display("FAIL %s done got=%b want=%b", tag, done, m_state == S_XFER); end
    total++;
    if (busy !== (m_state != S_IDLE)) begin bad++; $display("FAIL %s busy got=%b want=%b", tag, busy, m_state != S_IDLE); end
    total++;
    if (bitwidth !== m_bw) begin bad++; $display("FAIL %s bitwidth got=%0d want=%0d", tag, bitwidth, m_bw); end
`ifdef ACC_SCHED_STATS_EN
    total++;
    if (stat_writes !== 32'(m_writes)) begin bad++; $display("FAIL %s stat_writes got=%0d want=%0d", tag, stat_writes, m_writes); end
    total++;
    if (stat_stall !== 32'(m_stall)) begin bad++; $display("FAIL %s stat_stall got=%0d want=%0d", tag, stat_stall, m_stall); end
`endif
    // Model reaction to the coming edge.
    case (m_state)
      S_IDLE: begin
        m_en = 1'b0;
        if (start) begin
          m_state = S_ACC;
          m_bw = bitwidth_in;
          m_writes = 0;
          m_stall = 0;
        end
      end
      S_ACC: begin
        if (gi >= 0) begin
          m_en = 1'b1;
          m_row = req_row[gi*ROW_W +: ROW_W];
          m_col = req_col[gi*ROW_W +: ROW_W];
          m_data = req_data[gi*DATA_W +: DATA_W];
          m_last = gi;
          grant_log.push_back(gi);
          if (m_writes < 64'hFFFF_FFFF) m_writes++;
        end else begin
          m_en = 1'b0;
        end
        if ($countones(req_valid) > 1 && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (drain) m_state = S_FLUSH;
      end
      S_FLUSH: begin
        m_en = 1'b0;
        m_state = S_XFER;
      end
      default: begin
        m_en = 1'b0;
        m_state = S_IDLE;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    drain = 1'b0;
    bitwidth_in = 2'd0;
    req_valid = '0;
    req_row = '0;
    req_col = '0;
    req_data = '0;
    model_reset();
    #3;
    total++;
    if ({busy, done, transfer, buffer_write_enable} !== 4'b0) begin
      bad++; $display("FAIL reset strobes got=%b want=0000", {busy, done, transfer, buffer_write_enable});
    end
    total++;
    if ({buffer_row_write, buffer_column_write, buffer_data_write} !== '0) begin
      bad++; $display("FAIL reset bus got=%h want=0", {buffer_row_write, buffer_column_write, buffer_data_write});
    end
    total++;
    if (bitwidth !== 2'd0) begin bad++; $display("FAIL reset bitwidth got=%0d want=0", bitwidth); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_start();
    start = 1'b1;
    bitwidth_in = 2'd1;
    req_valid = '1;
    randomize_lanes();
    cycle("start");
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start busy got=%b want=1", busy); end
    total++;
    if (bitwidth !== 2'd1) begin bad++; $display("FAIL start bitwidth got=%0d want=1", bitwidth); end
  endtask

  task automatic test_round_robin();
    int base;
    base = grant_log.size();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      randomize_lanes();
      cycle("round_robin");
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (grant_log[base + c] != c % NUM_REQ) begin
        bad++; $display("FAIL rr_order slot %0d got=%0d want=%0d", c, grant_log[base + c], c % NUM_REQ);
      end
    end
  endtask

  task automatic test_single_req();
    randomize_lanes();
    req_valid = 4'b0100;
    req_row[2*ROW_W +: ROW_W] = 8'd5;
    req_data[2*DATA_W +: DATA_W] = 16'h0003;
    cycle("single_req");
    total++;
    if (grant_log[$] != 2) begin bad++; $display("FAIL single_req grant got=%0d want=2", grant_log[$]); end
    total++;
    if ({buffer_write_enable, buffer_row_write, buffer_data_write} !== {1'b1, 8'd5, 16'h0003}) begin
      bad++; $display("FAIL single_req bus got=%b/%0d/%h want=1/5/0003", buffer_write_enable, buffer_row_write, buffer_data_write);
    end
    req_valid = '0;
  endtask

  task automatic test_drain();
    randomize_lanes();
    req_valid = 4'b0010;
    drain = 1'b1;
    cycle("drain_grant");
    total++;
    if (grant_log[$] != 1) begin bad++; $display("FAIL drain grant got=%0d want=1", grant_log[$]); end
    drain = 1'b0;
    req_valid = '1;
    cycle("flush");
    total++;
    if ({transfer, done, buffer_write_enable} !== 3'b110) begin
      bad++; $display("FAIL xfer strobes got=%b want=110", {transfer, done, buffer_write_enable});
    end
    cycle("xfer");
    total++;
    if ({transfer, done, busy} !== 3'b000) begin
      bad++; $display("FAIL after_xfer strobes got=%b want=000", {transfer, done, busy});
    end
    cycle("idle");
    req_valid = '0;
  endtask

`ifdef ACC_SCHED_STATS_EN
  task automatic test_stats();
    start = 1'b1;
    cycle("stats_start");
    start = 1'b0;
    req_valid = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      randomize_lanes();
      cycle("stats_accum");
    end
    req_valid = '0;
    drain = 1'b1;
    cycle("stats_drain");
    drain = 1'b0;
    total++;
    if (stat_writes !== 32'd6) begin bad++; $display("FAIL stats writes got=%0d want=6", stat_writes); end
    total++;
    if (stat_stall !== 32'd6) begin bad++; $display("FAIL stats stall got=%0d want=6", stat_stall); end
    cycle("stats_flush");
    cycle("stats_xfer");
    start = 1'b1;
    cycle("stats_restart");
    start = 1'b0;
    total++;
    if ({stat_writes, stat_stall} !== 64'd0) begin
      bad++; $display("FAIL stats clear got=%0d/%0d want=0/0", stat_writes, stat_stall);
    end
  endtask
`endif

  task automatic test_reset_mid_tile();
    if (m_state == S_IDLE) begin
      start = 1'b1;
      cycle("mid_start");
      start = 1'b0;
    end
    req_valid = '1;
    randomize_lanes();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({req_ready, busy, done, transfer, buffer_write_enable, bitwidth} !== '0) begin
      bad++; $display("FAIL mid_reset outputs got=%b want=0", {req_ready, busy, done, transfer, buffer_write_enable, bitwidth});
    end
    total++;
    if ({buffer_row_write, buffer_column_write, buffer_data_write} !== '0) begin
      bad++; $display("FAIL mid_reset bus got=%h want=0", {buffer_row_write, buffer_column_write, buffer_data_write});
    end
    @(posedge clk);
    #1;
    total++;
    if ({transfer, buffer_write_enable} !== 2'b00) begin
      bad++; $display("FAIL mid_reset hold got=%b want=00", {transfer, buffer_write_enable});
    end
    reset_n = 1'b1;
    model_reset();
    start = 1'b1;
    bitwidth_in = 2'd2;
    cycle("restart");
    start = 1'b0;
    total++;
    if ({busy, bitwidth} !== 3'b110) begin bad++; $display("FAIL restart busy/bw got=%b want=110", {busy, bitwidth}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = NUM_REQ'($urandom);
      randomize_lanes();
      start = ($urandom_range(0, 3) == 0);
      drain = ($urandom_range(0, 7) == 0);
      bitwidth_in = 2'($urandom_range(0, 2));
      cycle("random");
    end
    start = 1'b0;
    drain = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_round_robin();
    test_single_req();
    test_drain();
`ifdef ACC_SCHED_STATS_EN
    test_stats();
`endif
    test_reset_mid_tile();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
